// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, decoder codes and
// the access legality check used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  localparam logic [1:0] STORE_W = 2'b00;
  localparam logic [1:0] STORE_H = 2'b01;
  localparam logic [1:0] STORE_B = 2'b10;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b011;
  localparam logic [2:0] LOAD_LHU = 3'b100;

  // High when the access must complete with err and never touch memory:
  // illegal width code or an address not aligned to the access width.
  function automatic logic lsu_bad_access(input logic       mem_write,
                                          input logic [1:0] store,
                                          input logic [2:0] load,
                                          input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (mem_write) begin
      case (store)
        STORE_W: bad = (off != 2'b00);
        STORE_H: bad = off[0];
        STORE_B: bad = 1'b0;
        default: bad = 1'b1;
      endcase
    end else begin
      case (load)
        LOAD_LB, LOAD_LBU: bad = 1'b0;
        LOAD_LH, LOAD_LHU: bad = off[0];
        LOAD_LW:           bad = (off != 2'b00);
        default:           bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane selection for sub-word accesses: extracts and extends the addressed
// byte/half of a read word, and merges store data into a read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  load,
  input  logic [1:0]  store,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Load path: pick the lane addressed by byte_off, then sign/zero extend.
  always_comb begin
    lane_byte = rd_word[{byte_off, 3'b000} +: 8];
    lane_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (load)
      LOAD_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
      LOAD_LH:  load_data = {{16{lane_half[15]}}, lane_half};
      LOAD_LW:  load_data = rd_word;
      LOAD_LBU: load_data = {24'h000000, lane_byte};
      LOAD_LHU: load_data = {16'h0000, lane_half};
      default:  load_data = '0;
    endcase
  end

  // Store path: replace the addressed lane of the read word with wdata LSBs.
  always_comb begin
    store_word = rd_word;
    case (store)
      STORE_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      STORE_H: begin
        if (byte_off[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access engine. Runs loads and stores against a
// word-wide req/ack memory port; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_write,
  input  logic [1:0]  store,
  input  logic [2:0]  load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  lsu_state_t  state;
  logic        op_we;
  logic [1:0]  op_store;
  logic [2:0]  op_load;
  logic [1:0]  op_off;
  logic [31:0] op_wdata;
  logic        err_flag;
  logic [31:0] ld_data;
  logic [CW-1:0] tmo_cnt;
  logic        timeout_hit;
  logic [31:0] lane_load;
  logic [31:0] lane_store;

  assign timeout_hit = (TIMEOUT_CYC != 0) && ((32'(tmo_cnt) + 32'd1) == TIMEOUT_CYC);

  lsu_lane_align u_align (
    .load       (op_load),
    .store      (op_store),
    .byte_off   (op_off),
    .rd_word    (dmem_rdata),
    .wdata      (op_wdata),
    .load_data  (lane_load),
    .store_word (lane_store)
  );

  // Access sequencer: accept, memory handshake(s), timeout, completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      op_we      <= 1'b0;
      op_store   <= '0;
      op_load    <= '0;
      op_off     <= '0;
      op_wdata   <= '0;
      err_flag   <= 1'b0;
      ld_data    <= '0;
      tmo_cnt    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // done high means the previous access completes this cycle
          if (start && !done) begin
            op_we     <= mem_write;
            op_store  <= store;
            op_load   <= load;
            op_off    <= addr[1:0];
            op_wdata  <= wdata;
            busy      <= 1'b1;
            dmem_addr <= {addr[31:2], 2'b00};
            tmo_cnt   <= '0;
            if (lsu_bad_access(mem_write, store, load, addr[1:0])) begin
              err_flag <= 1'b1;
              state    <= RESP;
            end else if (!mem_write || store != STORE_W) begin
              err_flag <= 1'b0;
              dmem_req <= 1'b1;
              dmem_we  <= 1'b0;
              state    <= RD_WAIT;
            end else begin
              err_flag   <= 1'b0;
              dmem_req   <= 1'b1;
              dmem_we    <= 1'b1;
              dmem_wdata <= wdata;
              state      <= WR_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (dmem_req && dmem_ack) begin
            // Sub-word store: req stays low for one cycle, WR_WAIT re-raises it
            dmem_req <= 1'b0;
            if (op_we) begin
              dmem_wdata <= lane_store;
              dmem_we    <= 1'b1;
              state      <= WR_WAIT;
            end else begin
              ld_data <= lane_load;
              state   <= RESP;
            end
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            err_flag <= 1'b1;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        WR_WAIT: begin
          if (!dmem_req) begin
            dmem_req <= 1'b1;
            tmo_cnt  <= '0;
          end else if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= RESP;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            err_flag <= 1'b1;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        RESP: begin
          done <= 1'b1;
          busy <= 1'b0;
          err  <= err_flag;
          if (!op_we && !err_flag) rdata <= ld_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a
// scoreboard of expected completions.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_write;
  logic [1:0]  store;
  logic [2:0]  load;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_write  (mem_write),
    .store      (store),
    .load       (load),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  // Memory model
  logic [31:0] mem [logic [29:0]];
  logic        ack_en    = 1'b1;
  logic        force_ack = 1'b0;
  int unsigned rd_cnt  = 0;
  int unsigned wr_cnt  = 0;
  int unsigned req_cyc = 0;
  logic [31:0] last_addr = '0;

  always @(negedge clk) begin
    dmem_ack   = (dmem_req && ack_en) || force_ack;
    dmem_rdata = mem.exists(dmem_addr[31:2]) ? mem[dmem_addr[31:2]] : 32'h0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (dmem_req) req_cyc++;
      if (dmem_req && dmem_ack) begin
        last_addr = dmem_addr;
        if (dmem_we) begin
          mem[dmem_addr[31:2]] = dmem_wdata;
          wr_cnt++;
        end else begin
          rd_cnt++;
        end
      end
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t sb_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one access, queue its expected completion, then wait (bounded) for done.
  task automatic run_op(input string tag, input logic mw, input logic [1:0] st,
                        input logic [2:0] ld, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int unsigned exp_lat);
    exp_t e;
    int unsigned lat;
    logic got;
    @(negedge clk);
    mem_write = mw;
    store     = st;
    load      = ld;
    addr      = a;
    wdata     = wd;
    start     = 1'b1;
    e.tag   = tag;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (done === 1'b1) begin
        lat = n;
        got = 1'b1;
        break;
      end
    end
    e = sb_q.pop_front();
    check({e.tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({e.tag, "_latency"}, lat, e.lat);
      check({e.tag, "_rdata"}, rdata, e.rdata);
      check({e.tag, "_err"}, 32'(err), 32'(e.err));
      check({e.tag, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r0, w0, q0;
    rst_n = 1'b0;
    start = 1'b0;
    mem_write = 1'b0;
    store = STORE_W;
    load = LOAD_LW;
    addr = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {28'd0, busy, done, err, dmem_req}, 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_daddr", dmem_addr, 32'd0);
    check("rst_dwdata", dmem_wdata, 32'd0);
    rst_n = 1'b1;

    // word load
    mem[30'h41] = 32'hDEADBEEF;
    run_op("lw", 1'b0, STORE_W, LOAD_LW, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    check("lw_addr", last_addr, 32'h104);

    // sub-word loads with sign/zero extension
    mem[30'h40] = 32'h80123456;
    run_op("lb",  1'b0, STORE_W, LOAD_LB,  32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    run_op("lbu", 1'b0, STORE_W, LOAD_LBU, 32'h103, 32'h0, 32'h00000080, 1'b0, 3);
    run_op("lh",  1'b0, STORE_W, LOAD_LH,  32'h102, 32'h0, 32'hFFFF8012, 1'b0, 3);
    run_op("lhu", 1'b0, STORE_W, LOAD_LHU, 32'h100, 32'h0, 32'h00003456, 1'b0, 3);

    // read-modify-write stores; rdata must keep the last load result
    mem[30'h40] = 32'h11223344;
    r0 = rd_cnt;
    w0 = wr_cnt;
    run_op("sb", 1'b1, STORE_B, LOAD_LW, 32'h102, 32'hFFFFFFAB, 32'h00003456, 1'b0, 5);
    check("sb_reads", rd_cnt - r0, 32'd1);
    check("sb_writes", wr_cnt - w0, 32'd1);
    check("sb_mem", mem[30'h40], 32'h11AB3344);
    run_op("sh", 1'b1, STORE_H, LOAD_LW, 32'h102, 32'h12345566, 32'h00003456, 1'b0, 5);
    check("sh_mem", mem[30'h40], 32'h55663344);
    r0 = rd_cnt;
    run_op("sw", 1'b1, STORE_W, LOAD_LW, 32'h108, 32'hCAFEF00D, 32'h00003456, 1'b0, 3);
    check("sw_mem", mem[30'h42], 32'hCAFEF00D);
    check("sw_no_read", rd_cnt - r0, 32'd0);

    // misaligned / illegal: err without any memory request
    q0 = req_cyc;
    run_op("lh_mis",  1'b0, STORE_W, LOAD_LH, 32'h101, 32'h0, 32'h00003456, 1'b1, 2);
    run_op("sw_mis",  1'b1, STORE_W, LOAD_LW, 32'h102, 32'h0, 32'h00003456, 1'b1, 2);
    run_op("ld_ill",  1'b0, STORE_W, 3'b101,  32'h104, 32'h0, 32'h00003456, 1'b1, 2);
    run_op("st_ill",  1'b1, 2'b11,   LOAD_LW, 32'h100, 32'h0, 32'h00003456, 1'b1, 2);
    check("bad_no_req", req_cyc - q0, 32'd0);

    // timeout on a load, then a stray ack while idle
    ack_en = 1'b0;
    q0 = req_cyc;
    r0 = rd_cnt;
    run_op("lw_tmo", 1'b0, STORE_W, LOAD_LW, 32'h104, 32'h0, 32'h00003456, 1'b1, 6);
    check("tmo_req_cycles", req_cyc - q0, 32'd4);
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_done", 32'(done), 32'd0);
      check("late_ack_req", 32'(dmem_req), 32'd0);
    end
    force_ack = 1'b0;
    check("late_ack_rdata", rdata, 32'h00003456);
    check("late_ack_reads", rd_cnt - r0, 32'd0);

    // timeout during the read phase of a sub-word store: no write follows
    w0 = wr_cnt;
    run_op("sb_tmo", 1'b1, STORE_B, LOAD_LW, 32'h101, 32'h00000077, 32'h00003456, 1'b1, 6);
    check("sb_tmo_writes", wr_cnt - w0, 32'd0);
    check("sb_tmo_mem", mem[30'h40], 32'h55663344);
    ack_en = 1'b1;

    // async reset while a word store waits for ack
    ack_en = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    mem_write = 1'b1;
    store = STORE_W;
    addr = 32'h10C;
    wdata = 32'h0BADF00D;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("wr_wait_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(dmem_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    run_op("lw_after_rst", 1'b0, STORE_W, LOAD_LW, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    check("rst_no_write", wr_cnt - w0, 32'd0);
    check("sb_queue_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
